// File: rtl/mux_sel_sequencer_pkg.sv
// Shared definitions for the mux select sequencer.
//   NCH    : number of mux channels (fixed by the 2-bit select)
//   SEL_W  : width of the select / channel index
//   state_e: sequencer FSM state encoding
package mux_sel_sequencer_pkg;

  localparam int unsigned NCH   = 4;
  localparam int unsigned SEL_W = 2;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StSettle = 2'd1,
    StSample = 2'd2,
    StDone   = 2'd3
  } state_e;

endpackage

// File: rtl/mux_sel_sequencer_if.sv
// Bus between the scan controller and its user / the 4:1 mux.
//   start   : request one scan frame (user -> sequencer)
//   en_mask : channel enable bits (user -> sequencer)
//   dwell   : extra settle cycles per channel (user -> sequencer)
//   mux_o   : mux output fed back (mux -> sequencer)
//   s       : registered mux select (sequencer -> mux)
//   sample  : frame result, bit k = channel k (sequencer -> user)
//   valid   : one-cycle frame-complete pulse (sequencer -> user)
//   busy    : sequencer not idle (sequencer -> user)
// master = user/mux side, slave = sequencer side.
interface mux_sel_sequencer_if
  import mux_sel_sequencer_pkg::*;
#(
  parameter int unsigned DW = 4
) ();

  logic             start;
  logic [NCH-1:0]   en_mask;
  logic [DW-1:0]    dwell;
  logic             mux_o;
  logic [SEL_W-1:0] s;
  logic [NCH-1:0]   sample;
  logic             valid;
  logic             busy;

  modport master (
    output start,
    output en_mask,
    output dwell,
    output mux_o,
    input  s,
    input  sample,
    input  valid,
    input  busy
  );

  modport slave (
    input  start,
    input  en_mask,
    input  dwell,
    input  mux_o,
    output s,
    output sample,
    output valid,
    output busy
  );

endinterface

// File: rtl/mux_sel_sequencer_next_chan_find.sv
// Combinational channel finder for the scan sequencer.
//   mask  : enabled channels
//   cur   : channel currently selected
//   first : 1 = return lowest enabled channel, 0 = lowest enabled channel above cur
//   idx   : channel found (0 when none)
//   found : a qualifying channel exists
module mux_sel_sequencer_next_chan_find
  import mux_sel_sequencer_pkg::*;
(
  input  logic [NCH-1:0]   mask,
  input  logic [SEL_W-1:0] cur,
  input  logic             first,
  output logic [SEL_W-1:0] idx,
  output logic             found
);

  // Scan from the top down so the last hit is the lowest qualifying index.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (mask[i] && (first || (SEL_W'(i) > cur))) begin
        idx   = SEL_W'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_sel_sequencer.sv
// Scan controller for a 4:1 bit mux: steps the select through the enabled channels in
// ascending order, waits dwell+1 settle cycles per channel, samples the mux output in a
// one-cycle SAMPLE state and presents the assembled 4-bit frame with a one-cycle valid.
//   clk : clock, all state on posedge
//   rst : synchronous active-high reset
//   bus : slave side of mux_sel_sequencer_if (start/en_mask/dwell/mux_o in,
//         s/sample/valid/busy out)
module mux_sel_sequencer
  import mux_sel_sequencer_pkg::*;
#(
  parameter int unsigned DW = 4
) (
  input logic                clk,
  input logic                rst,
  mux_sel_sequencer_if.slave bus
);

  state_e           state_q, state_d;
  logic [SEL_W-1:0] s_q, s_d;
  logic [NCH-1:0]   sample_q, sample_d;
  logic [NCH-1:0]   mask_q, mask_d;
  logic [DW-1:0]    dwell_q, dwell_d;
  logic [DW-1:0]    cnt_q, cnt_d;

  logic [NCH-1:0]   find_mask;
  logic             find_first;
  logic [SEL_W-1:0] find_idx;
  logic             find_found;

  // In IDLE the frame has not been latched yet, so search the live enable mask.
  assign find_first = (state_q == StIdle);
  assign find_mask  = find_first ? bus.en_mask : mask_q;

  mux_sel_sequencer_next_chan_find u_find (
    .mask  (find_mask),
    .cur   (s_q),
    .first (find_first),
    .idx   (find_idx),
    .found (find_found)
  );

  always_comb begin
    state_d  = state_q;
    s_d      = s_q;
    sample_d = sample_q;
    mask_d   = mask_q;
    dwell_d  = dwell_q;
    cnt_d    = cnt_q;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          mask_d   = bus.en_mask;
          dwell_d  = bus.dwell;
          sample_d = '0;
          if (find_found) begin
            state_d = StSettle;
            s_d     = find_idx;
            cnt_d   = bus.dwell;
          end else begin
            state_d = StDone;
          end
        end
      end
      StSettle: begin
        // Count down to zero rather than up to dwell so all-ones never wraps.
        if (cnt_q != '0) begin
          cnt_d = cnt_q - DW'(1);
        end else begin
          state_d = StSample;
        end
      end
      StSample: begin
        sample_d[s_q] = bus.mux_o;
        if (find_found) begin
          state_d = StSettle;
          s_d     = find_idx;
          cnt_d   = dwell_q;
        end else begin
          state_d = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      s_q      <= '0;
      sample_q <= '0;
      mask_q   <= '0;
      dwell_q  <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      s_q      <= s_d;
      sample_q <= sample_d;
      mask_q   <= mask_d;
      dwell_q  <= dwell_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.s      = s_q;
  assign bus.sample = sample_q;
  assign bus.valid  = (state_q == StDone);
  assign bus.busy   = (state_q != StIdle);

endmodule

// File: tb/tb_mux_sel_sequencer.sv
// Randomized bench: each frame's expected schedule is derived from the enabled-channel list
// (each channel owns dwell+2 cycles, valid one cycle after the last slot) and the mux value
// present in the last cycle of each channel's slot.
module tb_mux_sel_sequencer;

  localparam int unsigned DW = 4;

  logic clk = 1'b0;
  logic rst;
  logic [3:0] mux_in;

  always #5 clk = ~clk;

  mux_sel_sequencer_if #(.DW(DW)) bus ();

  // Behavioural stand-in for four_mux_2.
  assign bus.mux_o = mux_in[bus.s];

  mux_sel_sequencer #(.DW(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [3:0] exp_sample;
  logic [1:0] exp_s;

  task automatic check(input string tag, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic idle_cycle();
    @(posedge clk);
    #1;
    bus.start   = 1'b0;
    bus.en_mask = 4'($urandom);
    bus.dwell   = 4'($urandom);
    mux_in      = 4'($urandom);
    @(negedge clk);
    check("idle_busy", int'(bus.busy), 0);
    check("idle_valid", int'(bus.valid), 0);
    check("idle_s", int'(bus.s), int'(exp_s));
    check("idle_sample", int'(bus.sample), int'(exp_sample));
  endtask

  // abort_sel: 0 = run to completion, -1 = random reset point, >0 = reset in that cycle.
  task automatic run_frame(input logic [3:0] mask, input logic [3:0] dw, input bit rand_mux,
                           input logic [3:0] mux_fix, input int abort_sel);
    int chans[$];
    int slot;
    int tot;
    int abort_at;
    int idx;
    for (int k = 0; k < 4; k++) if (mask[k]) chans.push_back(k);
    slot = int'(dw) + 2;
    tot  = chans.size() * slot + 1;
    abort_at = abort_sel;
    if (abort_sel < 0) abort_at = (tot > 1) ? int'($urandom_range(1, tot - 1)) : 0;

    // Cycle 0: start presented while idle.
    @(posedge clk);
    #1;
    bus.start   = 1'b1;
    bus.en_mask = mask;
    bus.dwell   = dw;
    mux_in      = rand_mux ? 4'($urandom) : mux_fix;
    @(negedge clk);
    check("c0_busy", int'(bus.busy), 0);
    check("c0_valid", int'(bus.valid), 0);
    check("c0_s", int'(bus.s), int'(exp_s));
    check("c0_sample", int'(bus.sample), int'(exp_sample));
    exp_sample = 4'h0;

    for (int t = 1; t <= tot; t++) begin
      @(posedge clk);
      #1;
      // Mid-frame start pulses and input changes must be ignored.
      bus.start   = 1'($urandom);
      bus.en_mask = 4'($urandom);
      bus.dwell   = 4'($urandom);
      if (rand_mux) mux_in = 4'($urandom);
      if (t == abort_at) rst = 1'b1;
      @(negedge clk);
      check("busy", int'(bus.busy), 1);
      check("valid", int'(bus.valid), (t == tot) ? 1 : 0);
      check("sample_acc", int'(bus.sample), int'(exp_sample));
      if (t < tot) begin
        idx   = (t - 1) / slot;
        exp_s = 2'(chans[idx]);
        check("sel", int'(bus.s), int'(exp_s));
        if ((t % slot) == 0) exp_sample[chans[idx]] = mux_in[chans[idx]];
      end else begin
        check("sel_done", int'(bus.s), int'(exp_s));
      end
      if (t == abort_at) begin
        @(posedge clk);
        #1;
        rst       = 1'b0;
        bus.start = 1'b0;
        @(negedge clk);
        exp_s      = 2'd0;
        exp_sample = 4'h0;
        check("rst_busy", int'(bus.busy), 0);
        check("rst_valid", int'(bus.valid), 0);
        check("rst_s", int'(bus.s), 0);
        check("rst_sample", int'(bus.sample), 0);
        return;
      end
    end
  endtask

  initial begin
    rst         = 1'b1;
    bus.start   = 1'b0;
    bus.en_mask = 4'h0;
    bus.dwell   = 4'h0;
    mux_in      = 4'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_busy", int'(bus.busy), 0);
    check("reset_valid", int'(bus.valid), 0);
    check("reset_s", int'(bus.s), 0);
    check("reset_sample", int'(bus.sample), 0);
    rst        = 1'b0;
    exp_s      = 2'd0;
    exp_sample = 4'h0;

    // Directed frames.
    run_frame(4'hF, 4'h0, 1'b0, 4'b0110, 0);
    run_frame(4'hA, 4'h2, 1'b0, 4'hF, 0);
    run_frame(4'h0, 4'h0, 1'b1, 4'h0, 0);
    run_frame(4'h1, 4'hF, 1'b1, 4'h0, 0);
    run_frame(4'h1, 4'h3, 1'b1, 4'h0, 0);
    // Reset during the SAMPLE cycle of channel 2.
    run_frame(4'hF, 4'h1, 1'b0, 4'hF, 9);
    idle_cycle();

    for (int f = 0; f < 200; f++) begin
      logic [3:0] m;
      logic [3:0] d;
      m = 4'($urandom);
      d = ($urandom_range(0, 7) == 0) ? 4'hF : 4'($urandom_range(0, 3));
      run_frame(m, d, 1'b1, 4'h0, ($urandom_range(0, 9) == 0) ? -1 : 0);
      if ($urandom_range(0, 3) == 0) idle_cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
